// File: rtl/frame_checker.sv
// Receive-side frame checker: classifies 64b/8b control blocks, tracks frame
// structure and reports per-frame length/status plus saturating statistics.
module frame_checker #(
    parameter int unsigned LEN_RX_DATA     = 64,
    parameter int unsigned LEN_RX_CTRL     = 8,
    parameter int unsigned NB_LEN          = 16,
    parameter int unsigned NB_CNT          = 16,
    parameter int unsigned MAX_FRAME_BYTES = 9600
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_valid,
    input  logic [LEN_RX_DATA-1:0] i_rx_data,
    input  logic [LEN_RX_CTRL-1:0] i_rx_ctrl,
    input  logic                   i_clear_cnt,
    output logic                   o_block_valid,
    output logic [2:0]             o_block_type,
    output logic                   o_frame_done,
    output logic                   o_frame_good,
    output logic [NB_LEN-1:0]      o_frame_len,
    output logic                   o_seq_err,
    output logic [NB_CNT-1:0]      o_good_cnt,
    output logic [NB_CNT-1:0]      o_bad_cnt,
    output logic [NB_CNT-1:0]      o_err_cnt,
    output logic [1:0]             o_state
);

    typedef enum logic [2:0] {
        BtIdle    = 3'd0,
        BtOrd     = 3'd1,
        BtStart   = 3'd2,
        BtData    = 3'd3,
        BtTerm    = 3'd4,
        BtError   = 3'd5,
        BtInvalid = 3'd6
    } blk_e;

    typedef enum logic [1:0] {
        IdleSt  = 2'd0,
        InFrame = 2'd1
    } state_e;

    state_e            state_q, state_d;
    blk_e              type_q, type_d, blk_type;
    logic [NB_LEN-1:0] len_q, len_d, flen_q, flen_d, len_inc, len_add;
    logic [NB_LEN:0]   len_sum;
    logic              bv_q, bv_d, done_q, done_d, good_q, good_d, seq_q, seq_d;
    logic              inc_good, inc_bad, inc_err;
    logic [NB_CNT-1:0] good_cnt_q, bad_cnt_q, err_cnt_q;
    logic [2:0]        term_k;
    logic [7:0]        byte7;
    logic              all_idle, all_err, lows_ok;

    assign byte7 = i_rx_data[LEN_RX_DATA-1 -: 8];

    always_comb begin
        blk_type = BtInvalid;
        term_k   = '0;
        lows_ok  = 1'b0;
        all_idle = (i_rx_data == {8{8'h07}});
        all_err  = (i_rx_data == {8{8'hFE}});
        if (i_rx_ctrl == 8'hFF && all_idle) begin
            blk_type = BtIdle;
        end else if (i_rx_ctrl == 8'hFF && all_err) begin
            blk_type = BtError;
        end else if (i_rx_ctrl == 8'h80 && byte7 == 8'hFB) begin
            blk_type = BtStart;
        end else if (i_rx_ctrl == 8'h80 && (byte7 == 8'h9C || byte7 == 8'h5C)) begin
            blk_type = BtOrd;
        end else if (i_rx_ctrl == 8'h00) begin
            blk_type = BtData;
        end else begin
            // TERM K: terminator in byte 7-K, idles below it, data above
            for (int k = 0; k < 8; k++) begin
                lows_ok = 1'b1;
                for (int j = 0; j < 8; j++) begin
                    if (j < 7 - k && i_rx_data[8*j +: 8] != 8'h07) lows_ok = 1'b0;
                end
                if (i_rx_ctrl == (8'hFF >> k) && i_rx_data[8*(7-k) +: 8] == 8'hFD && lows_ok) begin
                    blk_type = BtTerm;
                    term_k   = 3'(k);
                end
            end
        end
    end

    assign len_inc = (blk_type == BtTerm) ? NB_LEN'(term_k) : NB_LEN'(8);
    assign len_sum = {1'b0, len_q} + {1'b0, len_inc};
    assign len_add = len_sum[NB_LEN] ? '1 : len_sum[NB_LEN-1:0];

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        type_d   = type_q;
        flen_d   = flen_q;
        good_d   = good_q;
        bv_d     = 1'b0;
        done_d   = 1'b0;
        seq_d    = 1'b0;
        inc_good = 1'b0;
        inc_bad  = 1'b0;
        inc_err  = 1'b0;
        if (!i_enable) begin
            state_d = IdleSt;
            len_d   = '0;
        end else if (i_valid) begin
            bv_d   = 1'b1;
            type_d = blk_type;
            unique case (state_q)
                InFrame: begin
                    if (blk_type == BtData) begin
                        len_d = len_add;
                    end else if (blk_type == BtTerm) begin
                        state_d  = IdleSt;
                        len_d    = '0;
                        done_d   = 1'b1;
                        flen_d   = len_add;
                        good_d   = (32'(len_add) <= MAX_FRAME_BYTES);
                        inc_good = good_d;
                        inc_bad  = !good_d;
                    end else begin
                        // Abort: a START restarts a fresh frame immediately
                        done_d  = 1'b1;
                        good_d  = 1'b0;
                        seq_d   = 1'b1;
                        flen_d  = len_q;
                        inc_bad = 1'b1;
                        inc_err = 1'b1;
                        if (blk_type == BtStart) begin
                            len_d = NB_LEN'(7);
                        end else begin
                            state_d = IdleSt;
                            len_d   = '0;
                        end
                    end
                end
                default: begin
                    if (blk_type == BtStart) begin
                        state_d = InFrame;
                        len_d   = NB_LEN'(7);
                    end else if (blk_type != BtIdle && blk_type != BtOrd) begin
                        seq_d   = 1'b1;
                        inc_err = 1'b1;
                    end
                end
            endcase
        end
    end

    function automatic logic [NB_CNT-1:0] cnt_next(input logic [NB_CNT-1:0] c,
                                                   input logic inc, input logic clr);
        if (clr) return '0;
        if (inc && c != '1) return c + 1'b1;
        return c;
    endfunction

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IdleSt;
            len_q      <= '0;
            type_q     <= BtIdle;
            flen_q     <= '0;
            good_q     <= 1'b0;
            bv_q       <= 1'b0;
            done_q     <= 1'b0;
            seq_q      <= 1'b0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            type_q     <= type_d;
            flen_q     <= flen_d;
            good_q     <= good_d;
            bv_q       <= bv_d;
            done_q     <= done_d;
            seq_q      <= seq_d;
            good_cnt_q <= cnt_next(good_cnt_q, inc_good, i_clear_cnt);
            bad_cnt_q  <= cnt_next(bad_cnt_q, inc_bad, i_clear_cnt);
            err_cnt_q  <= cnt_next(err_cnt_q, inc_err, i_clear_cnt);
        end
    end

    assign o_block_valid = bv_q;
    assign o_block_type  = type_q;
    assign o_frame_done  = done_q;
    assign o_frame_good  = good_q;
    assign o_frame_len   = flen_q;
    assign o_seq_err     = seq_q;
    assign o_good_cnt    = good_cnt_q;
    assign o_bad_cnt     = bad_cnt_q;
    assign o_err_cnt     = err_cnt_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_frame_checker.sv
// Bench for frame_checker: two instances (default limits, and a 16-byte / 4-bit
// counter variant) checked every cycle against a block-level model plus literals.
module tb_frame_checker;

    localparam logic [63:0] D_IDLE  = 64'h0707070707070707;
    localparam logic [63:0] D_ERR   = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] D_START = 64'hFB6879736963616C;
    localparam logic [63:0] D_DATA  = 64'h0123456789ABCDEF;
    localparam logic [63:0] D_ORD   = 64'h9C00000000000000;
    localparam logic [63:0] D_INV   = 64'h1200000000000000;
    localparam logic [63:0] D_TERM5 = 64'h1122334455FD0707;
    localparam logic [63:0] D_TERM2 = 64'hAABBFD0707070707;
    localparam logic [63:0] D_TERM0 = 64'hFD07070707070707;
    localparam logic [63:0] D_TERM7 = 64'h01020304050607FD;

    logic        clk, rst_n, en, valid, clr;
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        cmp_en;
    int          n_tests, n_fail;

    logic        bv1, done1, good1, seq1, bv2, done2, good2, seq2;
    logic [2:0]  bt1, bt2;
    logic [15:0] len1, len2, gc1, bc1, ec1;
    logic [3:0]  gc2, bc2, ec2;
    logic [1:0]  st1, st2;

    frame_checker u_dut1 (
        .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_valid(valid),
        .i_rx_data(data), .i_rx_ctrl(ctrl), .i_clear_cnt(clr),
        .o_block_valid(bv1), .o_block_type(bt1), .o_frame_done(done1),
        .o_frame_good(good1), .o_frame_len(len1), .o_seq_err(seq1),
        .o_good_cnt(gc1), .o_bad_cnt(bc1), .o_err_cnt(ec1), .o_state(st1)
    );

    frame_checker #(.MAX_FRAME_BYTES(16), .NB_CNT(4)) u_dut2 (
        .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_valid(valid),
        .i_rx_data(data), .i_rx_ctrl(ctrl), .i_clear_cnt(clr),
        .o_block_valid(bv2), .o_block_type(bt2), .o_frame_done(done2),
        .o_frame_good(good2), .o_frame_len(len2), .o_seq_err(seq2),
        .o_good_cnt(gc2), .o_bad_cnt(bc2), .o_err_cnt(ec2), .o_state(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit in_frame;
        int len;
        bit bv;
        int btype;
        bit done;
        bit good;
        int flen;
        bit seq;
        int gc;
        int bc;
        int ec;
    } mdl_t;

    mdl_t m1, m2;

    // Returns block type code; k receives the terminator position for TERM
    function automatic int classify(input logic [63:0] d, input logic [7:0] c, output int k);
        byte unsigned b[8];
        bit ok;
        k = 0;
        for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
        if (c == 8'hFF && d == D_IDLE) return 0;
        if (c == 8'hFF && d == D_ERR) return 5;
        if (c == 8'h80 && b[7] == 8'hFB) return 2;
        if (c == 8'h80 && (b[7] == 8'h9C || b[7] == 8'h5C)) return 1;
        if (c == 8'h00) return 3;
        for (int kk = 0; kk < 8; kk++) begin
            if (c == (8'hFF >> kk)) begin
                ok = (b[7-kk] == 8'hFD);
                for (int j = 0; j < 7 - kk; j++) if (b[j] != 8'h07) ok = 0;
                if (ok) begin
                    k = kk;
                    return 4;
                end
            end
        end
        return 6;
    endfunction

    function automatic mdl_t step(input mdl_t m, input bit v, input bit e, input logic [63:0] d,
                                  input logic [7:0] c, input bit cl, input int max_len,
                                  input int cmax);
        int t, k;
        bit ig, ib, ie;
        ig = 0; ib = 0; ie = 0;
        m.done = 0;
        m.seq  = 0;
        m.bv   = 0;
        if (!e) begin
            m.in_frame = 0;
            m.len      = 0;
        end else if (v) begin
            t       = classify(d, c, k);
            m.bv    = 1;
            m.btype = t;
            if (!m.in_frame) begin
                if (t == 2) begin
                    m.in_frame = 1;
                    m.len      = 7;
                end else if (t != 0 && t != 1) begin
                    m.seq = 1;
                    ie    = 1;
                end
            end else if (t == 3) begin
                m.len = (m.len + 8 > 65535) ? 65535 : m.len + 8;
            end else if (t == 4) begin
                m.done     = 1;
                m.flen     = (m.len + k > 65535) ? 65535 : m.len + k;
                m.good     = (m.flen <= max_len);
                ig         = m.good;
                ib         = !m.good;
                m.in_frame = 0;
                m.len      = 0;
            end else begin
                m.done = 1;
                m.good = 0;
                m.seq  = 1;
                m.flen = m.len;
                ib     = 1;
                ie     = 1;
                if (t == 2) m.len = 7;
                else begin
                    m.in_frame = 0;
                    m.len      = 0;
                end
            end
        end
        if (cl) begin
            m.gc = 0; m.bc = 0; m.ec = 0;
        end else begin
            if (ig && m.gc < cmax) m.gc++;
            if (ib && m.bc < cmax) m.bc++;
            if (ie && m.ec < cmax) m.ec++;
        end
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= '{default: 0};
            m2 <= '{default: 0};
        end else begin
            m1 <= step(m1, valid, en, data, ctrl, clr, 9600, 65535);
            m2 <= step(m2, valid, en, data, ctrl, clr, 16, 15);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp_dut(input string tag, input mdl_t m, input logic bv, input logic [2:0] bt,
                           input logic dn, input logic gd, input logic [15:0] fl, input logic sq,
                           input logic [15:0] gc, input logic [15:0] bc, input logic [15:0] ec,
                           input logic [1:0] st);
        chk({tag, ".block_valid"}, 32'(bv), 32'(m.bv));
        if (m.bv) chk({tag, ".block_type"}, 32'(bt), 32'(m.btype));
        chk({tag, ".frame_done"}, 32'(dn), 32'(m.done));
        if (m.done) chk({tag, ".frame_good"}, 32'(gd), 32'(m.good));
        chk({tag, ".frame_len"}, 32'(fl), 32'(m.flen));
        chk({tag, ".seq_err"}, 32'(sq), 32'(m.seq));
        chk({tag, ".good_cnt"}, 32'(gc), 32'(m.gc));
        chk({tag, ".bad_cnt"}, 32'(bc), 32'(m.bc));
        chk({tag, ".err_cnt"}, 32'(ec), 32'(m.ec));
        chk({tag, ".state"}, 32'(st), 32'(m.in_frame));
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            cmp_dut("dut1", m1, bv1, bt1, done1, good1, len1, seq1, gc1, bc1, ec1, st1);
            cmp_dut("dut2", m2, bv2, bt2, done2, good2, len2, seq2, 16'(gc2), 16'(bc2),
                    16'(ec2), st2);
        end
    end

    task automatic send(input logic [63:0] d, input logic [7:0] c, input logic v = 1'b1,
                        input logic e = 1'b1, input logic cl = 1'b0);
        @(negedge clk);
        data  = d;
        ctrl  = c;
        valid = v;
        en    = e;
        clr   = cl;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rst_bv"}, 32'(bv1 | bv2), 0);
        chk({tag, ".rst_type"}, 32'(bt1 | bt2), 0);
        chk({tag, ".rst_done"}, 32'(done1 | done2), 0);
        chk({tag, ".rst_len"}, 32'(len1 | len2), 0);
        chk({tag, ".rst_cnt"}, 32'(gc1 | bc1 | ec1 | 16'(gc2 | bc2 | ec2)), 0);
        chk({tag, ".rst_state"}, 32'(st1 | st2), 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cmp_en  = 0;
        rst_n   = 0;
        en      = 1;
        valid   = 0;
        clr     = 0;
        data    = '0;
        ctrl    = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        #2 rst_n = 1;
        cmp_en = 1;

        repeat (4) send(D_IDLE, 8'hFF);
        settle();
        chk("idle.type", 32'(bt1), 0);
        chk("idle.err_cnt", 32'(ec1), 0);

        // Good frame: 7 + 3*8 + 5 = 36
        send(D_START, 8'h80);
        repeat (3) send(D_DATA, 8'h00);
        send(D_TERM5, 8'h07);
        settle();
        chk("frameA.done", 32'(done1), 1);
        chk("frameA.good", 32'(good1), 1);
        chk("frameA.len", 32'(len1), 36);
        chk("frameA.good_cnt", 32'(gc1), 1);
        chk("frameA.good_small", 32'(good2), 0);

        // Aborted frame: 7 + 2*8 = 23
        send(D_START, 8'h80);
        repeat (2) send(D_DATA, 8'h00);
        send(D_IDLE, 8'hFF);
        settle();
        chk("abort.done", 32'(done1), 1);
        chk("abort.good", 32'(good1), 0);
        chk("abort.len", 32'(len1), 23);
        chk("abort.seq_err", 32'(seq1), 1);
        chk("abort.bad_cnt", 32'(bc1), 1);
        chk("abort.err_cnt", 32'(ec1), 1);
        chk("abort.state", 32'(st1), 0);

        send(D_DATA, 8'h00);
        settle();
        chk("idle_data.type", 32'(bt1), 3);
        chk("idle_data.seq", 32'(seq1), 1);
        send(D_ERR, 8'hFF);
        settle();
        chk("idle_err.type", 32'(bt1), 5);
        chk("idle_err.err_cnt", 32'(ec1), 3);

        // 25 bytes: good at 9600, bad at 16
        send(D_START, 8'h80);
        repeat (2) send(D_DATA, 8'h00);
        send(D_TERM2, 8'h3F);
        settle();
        chk("len25.good_small", 32'(good2), 0);
        chk("len25.len_small", 32'(len2), 25);
        chk("len25.bad_small", 32'(bc2), 3);
        chk("len25.good_big", 32'(good1), 1);

        send(D_START, 8'h80);
        send(D_TERM0, 8'hFF);
        settle();
        chk("len7.good_small", 32'(good2), 1);
        chk("len7.len_small", 32'(len2), 7);
        chk("len7.good_cnt_small", 32'(gc2), 1);

        send(D_START, 8'h80);
        send(D_DATA, 8'h00);
        send(D_TERM7, 8'h01);
        settle();
        chk("term7.len", 32'(len1), 22);

        send(D_ORD, 8'h80);
        send(D_INV, 8'h80);
        settle();
        chk("invalid.type", 32'(bt1), 6);
        chk("invalid.seq", 32'(seq1), 1);

        // Gap inside a frame, then START restarting mid-frame
        send(D_START, 8'h80);
        send(D_DATA, 8'h00);
        send(D_DATA, 8'h00, 1'b0);
        send(D_DATA, 8'h00);
        send(D_START, 8'h80);
        send(D_TERM0, 8'hFF);
        settle();
        chk("restart.len", 32'(len1), 7);
        chk("restart.good", 32'(good1), 1);

        // Disable drops the frame; the following TERM is out of sequence
        send(D_START, 8'h80);
        send(D_DATA, 8'h00);
        send(D_DATA, 8'h00, 1'b1, 1'b0);
        send(D_TERM0, 8'hFF);
        settle();
        chk("drop.seq", 32'(seq1), 1);
        chk("drop.done", 32'(done1), 0);

        repeat (16) send(D_DATA, 8'h00);
        settle();
        chk("sat.err_small", 32'(ec2), 15);
        send(D_DATA, 8'h00, 1'b1, 1'b1, 1'b1);
        settle();
        chk("clear.err_small", 32'(ec2), 0);
        chk("clear.err_big", 32'(ec1), 0);
        chk("clear.good_big", 32'(gc1), 0);

        // Reset mid-frame
        send(D_START, 8'h80);
        send(D_DATA, 8'h00);
        settle();
        #2;
        rst_n = 0;
        valid = 0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        #2 rst_n = 1;
        repeat (3) send(D_IDLE, 8'hFF);
        settle();
        chk("post_rst.done", 32'(done1), 0);
        chk("post_rst.state", 32'(st1), 0);
        chk("post_rst.bv", 32'(bv1), 1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
